// File: rtl/me_pkg.sv
// Shared types and constants for the full-search motion estimator.
package me_pkg;

    localparam int PIX_W         = 8;
    localparam int MACRO_DIM_DEF = 16;

    typedef logic [PIX_W-1:0] pix_t;
    // One macroblock column, row 0 in the least significant pixel.
    typedef pix_t [MACRO_DIM_DEF-1:0] pix_col_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_CUR = 3'd1,
        SEARCH   = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } me_state_e;

    function automatic int sad_width(input int macro_dim);
        return PIX_W + 2 * $clog2(macro_dim);
    endfunction

endpackage

// File: rtl/me_sad_tree.sv
// SAD of the current macroblock against the window: per-column abs-diff sums,
// then a column reduction, with one register stage on the result.
module me_sad_tree
    import me_pkg::*;
#(
    parameter int MACRO_DIM = 16,
    parameter int SAD_W     = sad_width(16)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [MACRO_DIM*MACRO_DIM*PIX_W-1:0] cur_pix,
    input  logic [MACRO_DIM*MACRO_DIM*PIX_W-1:0] win_pix,
    output logic [SAD_W-1:0]                     sad_q
);

    localparam int COL_W = PIX_W + $clog2(MACRO_DIM);

    logic [COL_W-1:0] col_sum_s [MACRO_DIM];
    logic [SAD_W-1:0] total_s;
    logic [SAD_W-1:0] sad_d;

    // Absolute differences summed down each column.
    always_comb begin
        logic [PIX_W-1:0] a_v;
        logic [PIX_W-1:0] b_v;
        a_v = '0;
        b_v = '0;
        for (int j = 0; j < MACRO_DIM; j++) begin
            col_sum_s[j] = '0;
            for (int r = 0; r < MACRO_DIM; r++) begin
                a_v = cur_pix[(j*MACRO_DIM + r)*PIX_W +: PIX_W];
                b_v = win_pix[(j*MACRO_DIM + r)*PIX_W +: PIX_W];
                col_sum_s[j] = col_sum_s[j] + COL_W'((a_v > b_v) ? (a_v - b_v) : (b_v - a_v));
            end
        end
    end

    // Column sums reduced to the block SAD; result held between candidates.
    always_comb begin
        total_s = '0;
        for (int j = 0; j < MACRO_DIM; j++) begin
            total_s = total_s + SAD_W'(col_sum_s[j]);
        end
        if (en) begin
            sad_d = total_s;
        end else begin
            sad_d = sad_q;
        end
    end

    // Result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sad_q <= '0;
        end else begin
            sad_q <= sad_d;
        end
    end

endmodule

// File: rtl/me_search.sv
// Full-search block motion estimator over a streamed search window.
// Optional feature: define ME_ZERO_BIAS_EN to favour the zero motion vector.
module me_search
    import me_pkg::*;
#(
    parameter int  MACRO_DIM    = 16,
    parameter int  SEARCH_RANGE = 16,
    parameter int  ZERO_BIAS    = 64,
    localparam int SEARCH_DIM   = MACRO_DIM + 2 * SEARCH_RANGE,
    localparam int SAD_W        = sad_width(MACRO_DIM),
    localparam int MV_W         = $clog2(SEARCH_RANGE) + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cpr_valid,
    input  logic [MACRO_DIM*PIX_W-1:0] cpr_col,
    input  logic                       spr_valid,
    input  logic [MACRO_DIM*PIX_W-1:0] spr_col,
    output logic                       cpr_ready,
    output logic                       spr_ready,
    output logic [SAD_W-1:0]           sad,
    output logic                       sad_valid,
    output logic signed [MV_W-1:0]     mv_x,
    output logic signed [MV_W-1:0]     mv_y,
    output logic [SAD_W-1:0]           best_sad,
    output logic                       done,
    output logic                       busy
);

    localparam int COL_BITS = MACRO_DIM * PIX_W;
    localparam int BLK_BITS = MACRO_DIM * COL_BITS;
    localparam int CNT_W    = $clog2(SEARCH_DIM + 1);
    localparam int DY_W     = $clog2(2 * SEARCH_RANGE + 1);
    localparam int LAST_DY  = 2 * SEARCH_RANGE;
`ifdef ME_ZERO_BIAS_EN
    localparam logic BIAS_ON = 1'b1;
`else
    localparam logic BIAS_ON = 1'b0;
`endif

    me_state_e state_q, state_d;
    logic [BLK_BITS-1:0]    cur_q, cur_d, win_q, win_d;
    logic [CNT_W-1:0]       load_cnt_q, load_cnt_d, col_cnt_q, col_cnt_d, col_next_s;
    logic [DY_W-1:0]        dy_q, dy_d;
    logic                   drain_q, drain_d;
    logic                   cand_v1_q, cand_v1_d, sad_valid_q, sad_valid_d;
    logic signed [MV_W-1:0] mvx1_q, mvx1_d, mvy1_q, mvy1_d, mvx2_q, mvx2_d, mvy2_q, mvy2_d;
    logic [SAD_W-1:0]       best_key_q, best_key_d, best_sad_q, best_sad_d;
    logic signed [MV_W-1:0] best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
    logic                   cpr_ready_q, cpr_ready_d, spr_ready_q, spr_ready_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   cand_zero_s, take_s;
    logic [SAD_W-1:0]       biased_s, key_s;

    me_sad_tree #(
        .MACRO_DIM (MACRO_DIM),
        .SAD_W     (SAD_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .en      (cand_v1_q),
        .cur_pix (cur_q),
        .win_pix (win_q),
        .sad_q   (sad)
    );

    // Sequencer: column intake, window shift, candidate issue and state.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        win_d      = win_q;
        load_cnt_d = load_cnt_q;
        col_cnt_d  = col_cnt_q;
        dy_d       = dy_q;
        drain_d    = drain_q;
        cand_v1_d  = 1'b0;
        mvx1_d     = mvx1_q;
        mvy1_d     = mvy1_q;
        col_next_s = col_cnt_q + CNT_W'(1);
        if (start) begin
            state_d    = LOAD_CUR;
            load_cnt_d = '0;
            col_cnt_d  = '0;
            dy_d       = '0;
            drain_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD_CUR: begin
                    if (cpr_valid) begin
                        cur_d[load_cnt_q*COL_BITS +: COL_BITS] = cpr_col;
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                        if (load_cnt_q == CNT_W'(MACRO_DIM - 1)) begin
                            state_d   = SEARCH;
                            col_cnt_d = '0;
                            dy_d      = '0;
                        end else begin
                            state_d = LOAD_CUR;
                        end
                    end else begin
                        state_d = LOAD_CUR;
                    end
                end
                SEARCH: begin
                    if (spr_valid) begin
                        // Newest column enters at the top; slot 0 is the oldest (leftmost dx).
                        win_d     = {spr_col, win_q[BLK_BITS-1:COL_BITS]};
                        col_cnt_d = col_next_s;
                        if (col_next_s >= CNT_W'(MACRO_DIM)) begin
                            cand_v1_d = 1'b1;
                            mvx1_d    = MV_W'(int'(col_next_s) - MACRO_DIM - SEARCH_RANGE);
                            mvy1_d    = MV_W'(int'(dy_q) - SEARCH_RANGE);
                        end else begin
                            cand_v1_d = 1'b0;
                        end
                        if (col_next_s == CNT_W'(SEARCH_DIM)) begin
                            col_cnt_d = '0;
                            if (dy_q == DY_W'(LAST_DY)) begin
                                state_d = DRAIN;
                                drain_d = 1'b0;
                            end else begin
                                dy_d = dy_q + DY_W'(1);
                            end
                        end else begin
                            state_d = SEARCH;
                        end
                    end else begin
                        state_d = SEARCH;
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_d = DONE;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Second pipeline stage, best-candidate tracker and registered handshakes.
    always_comb begin
        sad_valid_d = start ? 1'b0 : cand_v1_q;
        mvx2_d      = mvx1_q;
        mvy2_d      = mvy1_q;
        cand_zero_s = (mvx2_q == '0) && (mvy2_q == '0);
        biased_s    = (sad > SAD_W'(ZERO_BIAS)) ? (sad - SAD_W'(ZERO_BIAS)) : '0;
        key_s       = (BIAS_ON && cand_zero_s) ? biased_s : sad;
        // The biased key clamps at zero, so the zero vector must also win ties.
        take_s      = sad_valid_q && ((key_s < best_key_q) ||
                                      (BIAS_ON && cand_zero_s && (key_s == best_key_q)));
        if (start) begin
            best_key_d = '1;
            best_sad_d = '1;
            best_mvx_d = '0;
            best_mvy_d = '0;
        end else if (take_s) begin
            best_key_d = key_s;
            best_sad_d = sad;
            best_mvx_d = mvx2_q;
            best_mvy_d = mvy2_q;
        end else begin
            best_key_d = best_key_q;
            best_sad_d = best_sad_q;
            best_mvx_d = best_mvx_q;
            best_mvy_d = best_mvy_q;
        end
        cpr_ready_d = (state_d == LOAD_CUR);
        spr_ready_d = (state_d == SEARCH);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // Control and tracker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            col_cnt_q   <= '0;
            dy_q        <= '0;
            drain_q     <= 1'b0;
            cand_v1_q   <= 1'b0;
            sad_valid_q <= 1'b0;
            mvx1_q      <= '0;
            mvy1_q      <= '0;
            mvx2_q      <= '0;
            mvy2_q      <= '0;
            best_key_q  <= '0;
            best_sad_q  <= '0;
            best_mvx_q  <= '0;
            best_mvy_q  <= '0;
            cpr_ready_q <= 1'b0;
            spr_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            col_cnt_q   <= col_cnt_d;
            dy_q        <= dy_d;
            drain_q     <= drain_d;
            cand_v1_q   <= cand_v1_d;
            sad_valid_q <= sad_valid_d;
            mvx1_q      <= mvx1_d;
            mvy1_q      <= mvy1_d;
            mvx2_q      <= mvx2_d;
            mvy2_q      <= mvy2_d;
            best_key_q  <= best_key_d;
            best_sad_q  <= best_sad_d;
            best_mvx_q  <= best_mvx_d;
            best_mvy_q  <= best_mvy_d;
            cpr_ready_q <= cpr_ready_d;
            spr_ready_q <= spr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Pixel storage; contents are always written before use.
    always_ff @(posedge clk) begin
        cur_q <= cur_d;
        win_q <= win_d;
    end

    assign cpr_ready = cpr_ready_q;
    assign spr_ready = spr_ready_q;
    assign sad_valid = sad_valid_q;
    assign mv_x      = best_mvx_q;
    assign mv_y      = best_mvy_q;
    assign best_sad  = best_sad_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_me_search.sv
// Scoreboard bench for me_search: per-candidate SADs and timing, final vectors, abort, reset.
module tb_me_search;

    localparam int MD = 16;
    localparam int SR = 16;
    localparam int SD = MD + 2 * SR;
    localparam int NCAND = (2 * SR + 1) * (2 * SR + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cpr_valid = 1'b0;
    logic [MD*8-1:0]   cpr_col = '0;
    logic              spr_valid = 1'b0;
    logic [MD*8-1:0]   spr_col = '0;
    logic              cpr_ready, spr_ready, sad_valid, done, busy;
    logic [15:0]       sad, best_sad;
    logic signed [5:0] mv_x, mv_y;

    me_search dut (
        .clk(clk), .rst(rst), .start(start),
        .cpr_valid(cpr_valid), .cpr_col(cpr_col),
        .spr_valid(spr_valid), .spr_col(spr_col),
        .cpr_ready(cpr_ready), .spr_ready(spr_ready),
        .sad(sad), .sad_valid(sad_valid),
        .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] sad; int due; } exp_t;
    exp_t sb_q[$];

    logic [7:0] cur_px [MD][MD];
    logic [7:0] win_px [SD][SD];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int sv_count = 0;
    int done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every sad_valid must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sad_valid === 1'b1) begin
            sv_count++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sad_unexpected: got sad=%0d at cycle %0d, expected no sad_valid", sad, cyc);
            end else begin
                e = sb_q.pop_front();
                if (sad !== e.sad || cyc != e.due) begin
                    n_err++;
                    $display("FAIL sad_value: got sad=%0d at cycle %0d, expected %0d at cycle %0d",
                             sad, cyc, e.sad, e.due);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL sad_missing: no sad_valid by cycle %0d, expected sad=%0d at cycle %0d", cyc, e.sad, e.due);
        end
        if (done === 1'b1) done_count++;
    end

    function automatic int cand_sad(input int dx, input int dy);
        int s = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                int a = int'(cur_px[r][c]);
                int b = int'(win_px[dy + r][dx + c]);
                s += (a > b) ? (a - b) : (b - a);
            end
        return s;
    endfunction

    task automatic fill_const(input logic [7:0] cv, input logic [7:0] wv);
        for (int r = 0; r < SD; r++)
            for (int c = 0; c < SD; c++) win_px[r][c] = wv;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) cur_px[r][c] = cv;
    endtask

    task automatic fill_offset(input int ox, input int oy);
        for (int r = 0; r < SD; r++)
            for (int c = 0; c < SD; c++) win_px[r][c] = 8'($urandom_range(0, 255));
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) cur_px[r][c] = win_px[oy + SR + r][ox + SR + c];
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic load_cur();
        for (int c = 0; c < MD; c++) begin
            int w = 0;
            if (c == 5) @(negedge clk);
            for (int r = 0; r < MD; r++) cpr_col[r*8 +: 8] = cur_px[r][c];
            cpr_valid = 1'b1;
            while (cpr_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            if (w >= 20) begin
                n_cmp++; n_err++;
                $display("FAIL cpr_ready_timeout: cpr_ready=%b, expected 1 within 20 cycles", cpr_ready);
            end
            @(negedge clk) cpr_valid = 1'b0;
        end
    endtask

    task automatic send_spr(input int dy, input int c);
        int w = 0;
        for (int r = 0; r < MD; r++) spr_col[r*8 +: 8] = win_px[dy + r][c];
        spr_valid = 1'b1;
        while (spr_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL spr_ready_timeout: spr_ready=%b, expected 1 within 20 cycles", spr_ready);
            spr_valid = 1'b0;
        end else begin
            if (c + 1 >= MD) sb_q.push_back('{sad: 16'(cand_sad(c + 1 - MD, dy)), due: cyc + 2});
            @(negedge clk) spr_valid = 1'b0;
        end
    endtask

    task automatic run_search(input int abort_dy);
        for (int dy = 0; dy <= 2 * SR; dy++)
            for (int c = 0; c < SD; c++) begin
                if (dy == abort_dy && c == 10) return;
                send_spr(dy, c);
            end
    endtask

    task automatic wait_done(input int ex, input int ey, input int eb, input int sv0, input int dc0);
        int w = 0;
        while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (w >= 40) begin
            n_err++;
            $display("FAIL done_timeout: done=%b, expected 1 within 40 cycles", done);
        end
        n_cmp++;
        if (mv_x !== 6'(ex) || mv_y !== 6'(ey)) begin
            n_err++;
            $display("FAIL mv: got (%0d,%0d), expected (%0d,%0d)", mv_x, mv_y, ex, ey);
        end
        n_cmp++;
        if (best_sad !== 16'(eb)) begin
            n_err++;
            $display("FAIL best_sad: got %0d, expected %0d", best_sad, eb);
        end
        @(negedge clk);
        n_cmp++;
        if (done_count != dc0 + 1) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses, expected %0d", done_count - dc0, 1);
        end
        n_cmp++;
        if (sv_count != sv0 + NCAND || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sad_valid_count: got %0d (pending %0d), expected %0d", sv_count - sv0, sb_q.size(), NCAND);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mv_x !== 6'(ex) || best_sad !== 16'(eb)) begin
            n_err++;
            $display("FAIL after_done: busy=%b done=%b mv_x=%0d best_sad=%0d, expected 0 0 %0d %0d",
                     busy, done, mv_x, best_sad, ex, eb);
        end
    endtask

    task automatic run_full(input int ex, input int ey, input int eb);
        int sv0 = sv_count;
        int dc0 = done_count;
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || cpr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: busy=%b cpr_ready=%b, expected 1 1", busy, cpr_ready);
        end
        load_cur();
        run_search(-1);
        wait_done(ex, ey, eb, sv0, dc0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cpr_ready, spr_ready, sad_valid, done, busy, sad, mv_x, mv_y, best_sad} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected all zero",
                     {cpr_ready, spr_ready, sad_valid, done, busy, sad, mv_x, mv_y, best_sad});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cpr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b cpr_ready=%b, expected 0 0", busy, cpr_ready);
        end
    endtask

    task automatic test_flat();
        fill_const(8'h10, 8'h10);
`ifdef ME_ZERO_BIAS_EN
        run_full(0, 0, 0);
`else
        run_full(-16, -16, 0);
`endif
    endtask

    task automatic test_offset();
        fill_offset(3, -2);
        run_full(3, -2, 0);
    endtask

    task automatic test_max_sad();
        fill_const(8'hFF, 8'h00);
`ifdef ME_ZERO_BIAS_EN
        run_full(0, 0, 65280);
`else
        run_full(-16, -16, 65280);
`endif
    endtask

    task automatic test_abort();
        int dc0 = done_count;
        fill_offset(6, 1);
        pulse_start();
        load_cur();
        run_search(5);
        repeat (3) @(negedge clk);
        fill_offset(-5, 7);
        run_full(-5, 7, 0);
        n_cmp++;
        if (done_count != dc0 + 1) begin
            n_err++;
            $display("FAIL abort_done: got %0d done pulses, expected 1", done_count - dc0);
        end
    endtask

    task automatic test_rst_mid();
        int sv0;
        fill_offset(2, 2);
        pulse_start();
        load_cur();
        run_search(2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({cpr_ready, spr_ready, sad_valid, done, busy, sad, mv_x, mv_y, best_sad} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h, expected all zero",
                     {cpr_ready, spr_ready, sad_valid, done, busy, sad, mv_x, mv_y, best_sad});
        end
        sv0 = sv_count;
        spr_valid = 1'b1;
        repeat (6) @(negedge clk);
        spr_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || spr_ready !== 1'b0 || sv_count != sv0) begin
            n_err++;
            $display("FAIL idle_ignores_spr: busy=%b spr_ready=%b sad_valid pulses=%0d, expected 0 0 0",
                     busy, spr_ready, sv_count - sv0);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_offset();
        test_max_sad();
        test_abort();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
